// File: rtl/insn_pkg.sv
// RV32I encoder shared definitions: opcodes, fixed instruction words, field positions
// and the opcode-to-format classification used by the encoder and its immediate packer.
package insn_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_SYS,
        FMT_BAD
    } fmt_t;

    function automatic fmt_t fmt_of(input logic [6:0] op);
        case (op)
            OP_R:                     return FMT_R;
            OP_LOAD, OP_JALR, OP_IMM: return FMT_I;
            OP_STORE:                 return FMT_S;
            OP_BRANCH:                return FMT_B;
            OP_LUI, OP_AUIPC:         return FMT_U;
            OP_JAL:                   return FMT_J;
            OP_SYSTEM:                return FMT_SYS;
            default:                  return FMT_BAD;
        endcase
    endfunction

endpackage

// File: rtl/insn_imm_pack.sv
// Scatters the immediate into its instruction bit positions for the opcode's format and
// flags values that do not fit; purely combinational, no handshake.
module insn_imm_pack
    import insn_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    input  logic [4:0]  i_shamt,
    output logic [31:0] o_imm_bits,
    output logic        o_imm_err
);

    fmt_t w_fmt;
    logic w_shift;

    function automatic logic all_eq(input logic [20:0] v, input int n);
        logic [20:0] w_mask;
        w_mask = ~(21'h1f_ffff << n);
        return ((v & w_mask) == w_mask) || ((v & w_mask) == 21'h0);
    endfunction

    always_comb begin
        w_fmt      = fmt_of(i_opcode);
        w_shift    = (i_opcode == OP_IMM) && (i_funct3[1:0] == 2'b01);
        o_imm_bits = '0;
        o_imm_err  = 1'b0;
        case (w_fmt)
            FMT_I: begin
                if (w_shift) begin
                    o_imm_bits = {i_funct7, i_shamt, 20'b0};
                    // only SRAI may carry the arithmetic-shift funct7
                    o_imm_err  = !((i_funct7 == 7'b0000000) ||
                                   (i_funct7 == 7'b0100000 && i_funct3 == 3'b101));
                end else begin
                    o_imm_bits = {i_imm[11:0], 20'b0};
                    o_imm_err  = !all_eq(i_imm[31:11], 21);
                end
            end
            FMT_S: begin
                o_imm_bits = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
                o_imm_err  = !all_eq(i_imm[31:11], 21);
            end
            FMT_B: begin
                o_imm_bits = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
                o_imm_err  = i_imm[0] || !all_eq({1'b0, i_imm[31:12]}, 20);
            end
            FMT_U: begin
                o_imm_bits = {i_imm[31:12], 12'b0};
                o_imm_err  = |i_imm[11:0];
            end
            FMT_J: begin
                o_imm_bits = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
                o_imm_err  = i_imm[0] || !all_eq({9'b0, i_imm[31:20]}, 12);
            end
            FMT_SYS: begin
                o_imm_bits = {i_imm[11:0], 20'b0};
                o_imm_err  = |i_imm[31:1];
            end
            FMT_BAD: o_imm_err = 1'b1;
            default: o_imm_err = 1'b0;
        endcase
    end

endmodule

// File: rtl/insn_encoder.sv
// Packs an RV32I field bundle into an instruction word and streams it with an address;
// one-cycle registered latency, IN_READY drops only while the held word is stalled.
module insn_encoder
    import insn_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
    parameter int          DEPTH     = 1024,
    parameter int          CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [6:0]       OPCODE,
    input  logic [4:0]       RD,
    input  logic [4:0]       RS1,
    input  logic [4:0]       RS2,
    input  logic [2:0]       FUNCT3,
    input  logic [6:0]       FUNCT7,
    input  logic [31:0]      IMM,
    input  logic [4:0]       SHAMT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      OUT_INSN,
    output logic [31:0]      OUT_ADDR,
    output logic             OUT_ERR,
    output logic             ERR_SEEN,
    output logic [CNT_W-1:0] WORD_CNT
);

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

    fmt_t              w_fmt;
    logic [31:0]       w_imm_bits;
    logic              w_imm_err;
    logic [31:0]       w_regs;
    logic [31:0]       w_insn;
    logic              w_accept;
    logic              w_emit;

    logic              r_vld;
    logic [31:0]       r_insn;
    logic [31:0]       r_addr;
    logic              r_err;
    logic              r_err_seen;
    logic [CNT_W-1:0]  r_cnt;

    insn_imm_pack u_imm_pack (
        .i_opcode   (OPCODE),
        .i_funct3   (FUNCT3),
        .i_funct7   (FUNCT7),
        .i_imm      (IMM),
        .i_shamt    (SHAMT),
        .o_imm_bits (w_imm_bits),
        .o_imm_err  (w_imm_err)
    );

    always_comb begin
        w_fmt  = fmt_of(OPCODE);
        w_regs = '0;
        case (w_fmt)
            FMT_R: w_regs = (32'(FUNCT7) << F7_LSB) | (32'(RS2) << RS2_LSB) |
                            (32'(RS1) << RS1_LSB) | (32'(FUNCT3) << F3_LSB) |
                            (32'(RD) << RD_LSB);
            FMT_I: w_regs = (32'(RS1) << RS1_LSB) | (32'(FUNCT3) << F3_LSB) |
                            (32'(RD) << RD_LSB);
            FMT_S,
            FMT_B: w_regs = (32'(RS2) << RS2_LSB) | (32'(RS1) << RS1_LSB) |
                            (32'(FUNCT3) << F3_LSB);
            FMT_U,
            FMT_J: w_regs = 32'(RD) << RD_LSB;
            default: w_regs = '0;
        endcase
        w_insn = w_imm_bits | w_regs | {25'b0, OPCODE};
        if (w_fmt == FMT_BAD) begin
            w_insn = NOP;
        end else if (w_fmt == FMT_SYS && !w_imm_err) begin
            w_insn = IMM[0] ? EBREAK : ECALL;
        end
    end

    assign IN_READY  = !r_vld || OUT_READY;
    assign w_accept  = IN_VALID && IN_READY;
    assign w_emit    = r_vld && OUT_READY;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld      <= 1'b0;
            r_insn     <= '0;
            r_addr     <= BASE_ADDR;
            r_err      <= 1'b0;
            r_err_seen <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_accept) begin
                r_vld  <= 1'b1;
                r_insn <= w_insn;
                r_err  <= w_imm_err;
                if (w_imm_err) begin
                    r_err_seen <= 1'b1;
                end
            end else if (w_emit) begin
                r_vld <= 1'b0;
            end
            // OUT_ADDR names the held word, so it only moves once that word leaves
            if (w_emit) begin
                r_addr <= (r_addr == LAST_ADDR) ? BASE_ADDR : r_addr + 32'd4;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign OUT_VALID = r_vld;
    assign OUT_INSN  = r_insn;
    assign OUT_ADDR  = r_addr;
    assign OUT_ERR   = r_err;
    assign ERR_SEEN  = r_err_seen;
    assign WORD_CNT  = r_cnt;

endmodule

// File: tb/tb_insn_encoder.sv
// Self-checking bench for insn_encoder: directed scenarios plus a randomized stream
// compared against a range-based encoding model and an address/count scoreboard.
module tb_insn_encoder;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam int          DEP  = 4;
    localparam int          CW   = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          IN_VALID;
    logic          IN_READY;
    logic [6:0]    OPCODE;
    logic [4:0]    RD, RS1, RS2;
    logic [2:0]    FUNCT3;
    logic [6:0]    FUNCT7;
    logic [31:0]   IMM;
    logic [4:0]    SHAMT;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [31:0]   OUT_INSN;
    logic [31:0]   OUT_ADDR;
    logic          OUT_ERR;
    logic          ERR_SEEN;
    logic [CW-1:0] WORD_CNT;

    int checks = 0;
    int errors = 0;

    insn_encoder #(.BASE_ADDR(BASE), .DEPTH(DEP), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OPCODE(OPCODE), .RD(RD), .RS1(RS1), .RS2(RS2),
        .FUNCT3(FUNCT3), .FUNCT7(FUNCT7), .IMM(IMM), .SHAMT(SHAMT),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_INSN(OUT_INSN), .OUT_ADDR(OUT_ADDR), .OUT_ERR(OUT_ERR),
        .ERR_SEEN(ERR_SEEN), .WORD_CNT(WORD_CNT)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
        OPCODE = '0; RD = '0; RS1 = '0; RS2 = '0; FUNCT3 = '0; FUNCT7 = '0; IMM = '0; SHAMT = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm, input logic [4:0] sh);
        IN_VALID = 1'b1; OPCODE = op; RD = rd; RS1 = rs1; RS2 = rs2;
        FUNCT3 = f3; FUNCT7 = f7; IMM = imm; SHAMT = sh;
    endtask

    // Reference: legality from signed ranges / divisibility, layout from the format tables
    function automatic void model(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] imm, input logic [4:0] sh,
                                  output logic [31:0] w, output logic e);
        longint s;
        s = longint'($signed(imm));
        w = 32'h0; e = 1'b0;
        case (op)
            7'h33: w = {f7, rs2, rs1, f3, rd, op};
            7'h03, 7'h67, 7'h13: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    w = {f7, sh, rs1, f3, rd, op};
                    e = !(f7 == 7'd0 || (f7 == 7'd32 && f3 == 3'd5));
                end else begin
                    w = {imm[11:0], rs1, f3, rd, op};
                    e = (s < -2048) || (s > 2047);
                end
            end
            7'h23: begin
                w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                e = (s < -2048) || (s > 2047);
            end
            7'h63: begin
                w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                e = ((s % 2) != 0) || (s < -4096) || (s > 4095);
            end
            7'h37, 7'h17: begin
                w = {imm[31:12], rd, op};
                e = (imm % 4096) != 0;
            end
            7'h6F: begin
                w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                e = ((s % 2) != 0) || (s < -1048576) || (s > 1048575);
            end
            7'h73: begin
                w = {imm[11:0], 13'b0, op};
                e = !(imm == 32'd0 || imm == 32'd1);
            end
            default: begin
                w = 32'h0000_0013;
                e = 1'b1;
            end
        endcase
    endfunction

    task automatic gen_bundle();
        logic [31:0] imm;
        case ($urandom_range(0, 10))
            0: OPCODE = 7'h33;  1: OPCODE = 7'h03;  2: OPCODE = 7'h13;  3: OPCODE = 7'h67;
            4: OPCODE = 7'h23;  5: OPCODE = 7'h63;  6: OPCODE = 7'h17;  7: OPCODE = 7'h37;
            8: OPCODE = 7'h6F;  9: OPCODE = 7'h73;  default: OPCODE = 7'h0F;
        endcase
        case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: begin imm = $urandom_range(0, 8191); imm = imm - 32'd4096; end
            2: imm = $urandom & 32'hFFFF_F000;
            default: imm = $urandom_range(0, 2);
        endcase
        IMM = imm;
        RD = 5'($urandom); RS1 = 5'($urandom); RS2 = 5'($urandom);
        FUNCT3 = 3'($urandom); SHAMT = 5'($urandom);
        case ($urandom_range(0, 2))
            0: FUNCT7 = 7'd0;
            1: FUNCT7 = 7'd32;
            default: FUNCT7 = 7'($urandom);
        endcase
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", OUT_VALID); end
        checks++; if (OUT_INSN !== 32'h0) begin errors++; $display("FAIL reset_insn: got %h want 0", OUT_INSN); end
        checks++; if (OUT_ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", OUT_ERR); end
        checks++; if (ERR_SEEN !== 1'b0) begin errors++; $display("FAIL reset_err_seen: got %b want 0", ERR_SEEN); end
        checks++; if (WORD_CNT !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", WORD_CNT); end
        checks++; if (OUT_ADDR !== BASE) begin errors++; $display("FAIL reset_addr: got %h want %h", OUT_ADDR, BASE); end
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", IN_READY); end
    endtask

    task automatic test_addi();
        do_reset();
        drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 5'd0);
        tick();
        IN_VALID = 1'b0;
        checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", OUT_VALID); end
        checks++; if (OUT_INSN !== 32'h0050_0093) begin errors++; $display("FAIL addi_insn: got %h want 00500093", OUT_INSN); end
        checks++; if (OUT_ADDR !== BASE) begin errors++; $display("FAIL addi_addr: got %h want %h", OUT_ADDR, BASE); end
        checks++; if (OUT_ERR !== 1'b0) begin errors++; $display("FAIL addi_err: got %b want 0", OUT_ERR); end
        OUT_READY = 1'b1;
        tick();
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL addi_drain: got %b want 0", OUT_VALID); end
        checks++; if (WORD_CNT !== 4'd1) begin errors++; $display("FAIL addi_cnt: got %0d want 1", WORD_CNT); end
        OUT_READY = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h0020_81B3; exp_w[1] = 32'h0020_A423;
        exp_w[2] = 32'h0080_00EF; exp_w[3] = 32'h1234_52B7;
        do_reset();
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 5'd0);
                1: drive(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 5'd0);
                2: drive(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 5'd0);
                default: drive(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 5'd0);
            endcase
            #1;
            checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, IN_READY); end
            tick();
            checks++; if (OUT_VALID !== 1'b1 || OUT_INSN !== exp_w[i])
                begin errors++; $display("FAIL b2b_insn[%0d]: got v=%b %h want %h", i, OUT_VALID, OUT_INSN, exp_w[i]); end
            checks++; if (OUT_ADDR !== BASE + 32'(4 * i))
                begin errors++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, OUT_ADDR, BASE + 32'(4 * i)); end
        end
        IN_VALID = 1'b0;
        tick();
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", OUT_VALID); end
        checks++; if (WORD_CNT !== 4'd4) begin errors++; $display("FAIL b2b_cnt: got %0d want 4", WORD_CNT); end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 5'd0);
        tick();
        drive(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", k, IN_READY); end
            checks++; if (OUT_INSN !== 32'h0050_0093 || OUT_ADDR !== BASE)
                begin errors++; $display("FAIL bp_hold[%0d]: got %h@%h want 00500093@%h", k, OUT_INSN, OUT_ADDR, BASE); end
            tick();
        end
        OUT_READY = 1'b1;
        #1;
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", IN_READY); end
        tick();
        IN_VALID = 1'b0;
        checks++; if (OUT_INSN !== 32'h0020_81B3 || OUT_ADDR !== BASE + 32'd4)
            begin errors++; $display("FAIL bp_second: got %h@%h want 002081b3@%h", OUT_INSN, OUT_ADDR, BASE + 32'd4); end
        checks++; if (WORD_CNT !== 4'd1) begin errors++; $display("FAIL bp_cnt1: got %0d want 1", WORD_CNT); end
        tick();
        checks++; if (OUT_VALID !== 1'b0 || WORD_CNT !== 4'd2)
            begin errors++; $display("FAIL bp_cnt2: got v=%b cnt=%0d want v=0 cnt=2", OUT_VALID, WORD_CNT); end
    endtask

    task automatic test_errors();
        do_reset();
        OUT_READY = 1'b1;
        drive(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 5'd0);
        tick();
        checks++; if (OUT_ERR !== 1'b1 || ERR_SEEN !== 1'b1)
            begin errors++; $display("FAIL err_branch: got err=%b seen=%b want 1 1", OUT_ERR, ERR_SEEN); end
        checks++; if (OUT_INSN !== 32'h0020_8163) begin errors++; $display("FAIL err_branch_insn: got %h want 00208163", OUT_INSN); end
        drive(7'h0F, 5'd3, 5'd4, 5'd5, 3'd1, 7'd9, 32'h55, 5'd2);
        tick();
        checks++; if (OUT_INSN !== 32'h0000_0013 || OUT_ERR !== 1'b1)
            begin errors++; $display("FAIL err_unknown: got %h err=%b want 00000013 err=1", OUT_INSN, OUT_ERR); end
        drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 5'd0);
        tick();
        IN_VALID = 1'b0;
        checks++; if (OUT_ERR !== 1'b0 || OUT_INSN !== 32'h0050_0093)
            begin errors++; $display("FAIL err_legal_after: got %h err=%b want 00500093 err=0", OUT_INSN, OUT_ERR); end
        tick();
        checks++; if (ERR_SEEN !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", ERR_SEEN); end
    endtask

    task automatic test_wrap();
        do_reset();
        OUT_READY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), 5'd0);
            tick();
            checks++; if (OUT_ADDR !== BASE + 32'(4 * (i % DEP)))
                begin errors++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, OUT_ADDR, BASE + 32'(4 * (i % DEP))); end
        end
        IN_VALID = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        OUT_READY = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 5'd0);
            tick();
        end
        IN_VALID = 1'b0;
        tick();
        checks++; if (WORD_CNT !== 4'hF) begin errors++; $display("FAIL cnt_saturate: got %0d want 15", WORD_CNT); end
    endtask

    task automatic test_reset_stall();
        do_reset();
        OUT_READY = 1'b1;
        drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 5'd0);
        tick();
        drive(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 5'd0);
        tick();
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        tick();
        checks++; if (OUT_VALID !== 1'b1 || OUT_ADDR !== BASE + 32'd4)
            begin errors++; $display("FAIL rst_stall_setup: got v=%b %h want v=1 %h", OUT_VALID, OUT_ADDR, BASE + 32'd4); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (OUT_VALID !== 1'b0 || WORD_CNT !== '0)
            begin errors++; $display("FAIL rst_stall_clear: got v=%b cnt=%0d want 0 0", OUT_VALID, WORD_CNT); end
        OUT_READY = 1'b1;
        drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 5'd0);
        tick();
        IN_VALID = 1'b0;
        checks++; if (OUT_ADDR !== BASE) begin errors++; $display("FAIL rst_stall_addr: got %h want %h", OUT_ADDR, BASE); end
        tick();
        checks++; if (WORD_CNT !== 4'd1) begin errors++; $display("FAIL rst_stall_cnt: got %0d want 1", WORD_CNT); end
    endtask

    task automatic test_random(input int n);
        logic [31:0] q_insn [$];
        logic        q_err [$];
        logic [31:0] ew;
        logic        ee;
        logic        pend, seen_m, exp_rdy, acc, emt;
        int          sent, emitted, cyc, cnt_m;
        pend = 1'b0; seen_m = 1'b0; sent = 0; emitted = 0; cyc = 0; cnt_m = 0;
        do_reset();
        while ((sent < n || pend || q_insn.size() != 0) && cyc < 20000) begin
            cyc++;
            if (!pend && sent < n && $urandom_range(0, 3) != 0) begin
                gen_bundle();
                pend = 1'b1;
            end
            IN_VALID  = pend;
            OUT_READY = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = (q_insn.size() == 0) || OUT_READY;
            checks++; if (OUT_VALID !== (q_insn.size() != 0))
                begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, OUT_VALID, q_insn.size() != 0); end
            checks++; if (IN_READY !== exp_rdy)
                begin errors++; $display("FAIL rnd_in_ready c%0d: got %b want %b", cyc, IN_READY, exp_rdy); end
            if (q_insn.size() != 0) begin
                checks++; if (OUT_INSN !== q_insn[0] || OUT_ERR !== q_err[0])
                    begin errors++; $display("FAIL rnd_word c%0d: got %h err=%b want %h err=%b", cyc, OUT_INSN, OUT_ERR, q_insn[0], q_err[0]); end
                checks++; if (OUT_ADDR !== BASE + 32'(4 * (emitted % DEP)))
                    begin errors++; $display("FAIL rnd_addr c%0d: got %h want %h", cyc, OUT_ADDR, BASE + 32'(4 * (emitted % DEP))); end
            end
            checks++; if (WORD_CNT !== CW'(cnt_m) || ERR_SEEN !== seen_m)
                begin errors++; $display("FAIL rnd_status c%0d: got cnt=%0d seen=%b want cnt=%0d seen=%b", cyc, WORD_CNT, ERR_SEEN, cnt_m, seen_m); end
            acc = pend && exp_rdy;
            emt = (q_insn.size() != 0) && OUT_READY;
            if (emt) begin
                void'(q_insn.pop_front());
                void'(q_err.pop_front());
                emitted++;
                if (cnt_m < (1 << CW) - 1) cnt_m++;
            end
            if (acc) begin
                model(OPCODE, RD, RS1, RS2, FUNCT3, FUNCT7, IMM, SHAMT, ew, ee);
                q_insn.push_back(ew);
                q_err.push_back(ee);
                if (ee) seen_m = 1'b1;
                pend = 1'b0;
                sent++;
            end
            tick();
        end
        checks++; if (cyc >= 20000) begin errors++; $display("FAIL rnd_timeout: sent %0d of %0d", sent, n); end
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_wrap();
        test_saturate();
        test_reset_stall();
        test_random(400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
